m_imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a byte stream (valid/ready), packs bytes

---
 rtl/proc_pkg.sv | 14 +
 rtl/m_byte_packer.sv | 31 +++
 rtl/m_imem_loader.sv | 110 +++++++++++
 tb/tb_m_imem_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared loader/core package: loader state encoding and RV32 constants that the
// loader and the benches building instruction words both use.
package proc_pkg;
  localparam int         WORD_BYTES = 4;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_CHK,
    LD_DONE
  } ld_state_e;
endpackage

// File: rtl/m_byte_packer.sv
// 4-byte little-endian shift assembler. o_full marks the push that completes a word,
// so the caller can move to its write cycle on the same edge.
module m_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);
  logic [31:0] r_word;
  logic [1:0]  r_bcnt;

  // Shifting in from the top leaves byte 0 in [7:0] once four bytes have arrived.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_bcnt <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_bcnt <= '0;
    end else if (i_push) begin
      r_word <= {i_byte, r_word[31:8]};
      r_bcnt <= r_bcnt + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_full = i_push & (r_bcnt == 2'd3);
endmodule

// File: rtl/m_imem_loader.sv
// Byte-stream to imem writer: packs bytes into RV32 words and holds the core while loading.
// Optional trailing XOR checksum check when IMEM_LOADER_CHKSUM_EN is defined.
module m_imem_loader
  import proc_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_start,
  input  logic [ADDR_W:0] w_len,
  input  logic            w_in_valid,
  input  logic [7:0]      w_in_data,
  output logic            w_in_ready,
  output logic            w_we,
  output logic [31:0]     w_wa,
  output logic [31:0]     w_wd,
  output logic            w_busy,
  output logic            w_cpu_hold,
  output logic            w_done,
  output logic            w_err
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam ld_state_e LD_END = LD_CHK;
`else
  localparam ld_state_e LD_END = LD_DONE;
`endif

  ld_state_e       r_state;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_idx;
  logic            w_accept;
  logic            w_push;
  logic            w_clr;
  logic            w_full;
  logic [31:0]     w_word;

  assign w_in_ready = (r_state == LD_RECV) || (r_state == LD_CHK);
  assign w_accept   = w_in_valid & w_in_ready;
  assign w_push     = w_accept & (r_state == LD_RECV);
  assign w_clr      = (r_state == LD_IDLE) & w_start;

  m_byte_packer u_packer (
    .i_clk   (w_clk),
    .i_rst_n (w_rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_byte  (w_in_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= LD_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        LD_IDLE: if (w_start) begin
          r_len   <= (w_len > DEPTH) ? DEPTH : w_len;
          r_idx   <= '0;
          r_state <= (w_len == '0) ? LD_END : LD_RECV;
        end
        LD_RECV:  if (w_full) r_state <= LD_WRITE;
        LD_WRITE: if (r_idx + 1'b1 == r_len) begin
          r_state <= LD_END;
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_state <= LD_RECV;
        end
        LD_CHK:   if (w_accept) r_state <= LD_DONE;
        default:  r_state <= LD_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0] r_xor;
  logic       r_err;

  // Error stays up through DONE/IDLE so the host can read it after the pulse.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_xor <= '0;
      r_err <= 1'b0;
    end else if (w_clr) begin
      r_xor <= '0;
      r_err <= 1'b0;
    end else if (w_push) begin
      r_xor <= r_xor ^ w_in_data;
    end else if (w_accept && (r_state == LD_CHK)) begin
      r_err <= (w_in_data != r_xor);
    end
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign w_we       = (r_state == LD_WRITE);
  assign w_wa       = BASE_ADDR + 32'(r_idx) * 32'(WORD_BYTES);
  assign w_wd       = w_word;
  assign w_busy     = (r_state != LD_IDLE);
  assign w_cpu_hold = w_busy;
  assign w_done     = (r_state == LD_DONE);
endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: cycle tables for the basic loads plus hand sequences
// for reset mid-word, checksum and length saturation (IMEM_LOADER_CHKSUM_EN aware).
`timescale 1ns/1ps
module tb_m_imem_loader;
  import proc_pkg::*;
  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h40;

  logic          w_clk = 1'b0, w_rst_n = 1'b0, w_start = 1'b0, w_in_valid = 1'b0;
  logic [AW:0]   w_len = '0;
  logic [7:0]    w_in_data = '0;
  logic          w_in_ready, w_we, w_busy, w_cpu_hold, w_done, w_err;
  logic [31:0]   w_wa, w_wd;
  int            total = 0, bad = 0;

  always #5 w_clk = ~w_clk;

  m_imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start), .w_len(w_len),
    .w_in_valid(w_in_valid), .w_in_data(w_in_data), .w_in_ready(w_in_ready),
    .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_busy(w_busy), .w_cpu_hold(w_cpu_hold),
    .w_done(w_done), .w_err(w_err)
  );

  typedef struct packed {
    logic        start;
    logic [AW:0] len;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        vec[$];
  logic [63:0] wr_q[$];
  logic [7:0]  bq[$];

  always @(negedge w_clk) if (w_rst_n && w_we) wr_q.push_back({w_wa, w_wd});

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic row(input logic s, input int l, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [31:0] wa,
                     input logic [31:0] wd, input logic busy, input logic done);
    vec_t r;
    r.start = s; r.len = l[AW:0]; r.vld = v; r.dat = d; r.rdy = rdy; r.we = we;
    r.wa = wa; r.wd = wd; r.busy = busy; r.done = done;
    vec.push_back(r);
  endtask

  task automatic recv(input logic [7:0] d);   row(0, 0, 1, d, 1, 0, 0, 0, 1, 0); endtask
  task automatic gap();                       row(0, 0, 0, 0, 1, 0, 0, 0, 1, 0); endtask
  task automatic wr(input logic [31:0] wa, input logic [31:0] wd, input logic v, input logic [7:0] d);
    row(0, 0, v, d, 0, 1, wa, wd, 1, 0);
  endtask
  task automatic done_r();                    row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); endtask
  task automatic idle_r();                    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Entered and left at posedge+1; outputs are checked while the row's inputs are held.
  task automatic run_table(input string tag);
    foreach (vec[i]) begin
      w_start = vec[i].start; w_len = vec[i].len; w_in_valid = vec[i].vld; w_in_data = vec[i].dat;
      #1;
      check($sformatf("%s[%0d]", tag, i),
            {w_in_ready, w_we, w_busy, w_cpu_hold, w_done, w_err,
             vec[i].we ? w_wa : 32'h0, vec[i].we ? w_wd : 32'h0},
            {vec[i].rdy, vec[i].we, vec[i].busy, vec[i].busy, vec[i].done, 1'b0,
             vec[i].we ? vec[i].wa : 32'h0, vec[i].we ? vec[i].wd : 32'h0});
      @(posedge w_clk); #1;
    end
    w_start = 0; w_in_valid = 0; w_in_data = 0;
    vec.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    w_in_valid = 1; w_in_data = b;
    while (!w_in_ready && n < 50) begin @(posedge w_clk); #1; n++; end
    if (!w_in_ready) check("byte_timeout", 0, 1);
    @(posedge w_clk); #1;
    w_in_valid = 0;
  endtask

  task automatic start_load(input int len);
    w_start = 1; w_len = len[AW:0];
    @(posedge w_clk); #1;
    w_start = 0;
  endtask

  task automatic finish_load(input string tag);
    int n = 0;
    foreach (bq[i]) send_byte(bq[i]);
    while (!w_done && n < 200) begin @(posedge w_clk); #1; n++; end
    check({tag, "_done"}, w_done, 1);
    @(posedge w_clk); #1;
  endtask

  function automatic logic [31:0] mkw(input int i);
    return {7'b0, 5'(i), 5'd1, 3'b000, 5'(i + 1), OPC_OP};
  endfunction

  logic [7:0]  b1[8] = '{8'hB3, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h00, 8'h00};
  logic [7:0]  ck;
  logic [31:0] w;

  initial begin
    #12;
    check("reset", {w_in_ready, w_we, w_busy, w_cpu_hold, w_done, w_err, w_wa, w_wd},
          {6'b0, BASE, 32'h0});
    @(posedge w_clk); #1;
    w_rst_n = 1;

    // Test 1: back-to-back two-word load.
    row(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) recv(b1[i]);
    wr(BASE, 32'h001000B3, 0, 0);
    for (int i = 4; i < 8; i++) recv(b1[i]);
    wr(BASE + 4, 32'h000080B3, 0, 0);
`ifdef IMEM_LOADER_CHKSUM_EN
    recv(8'h90);
`endif
    done_r(); idle_r();
    run_table("t1");

    // Test 2: valid gaps, a byte held across WRITE, start ignored while busy.
    row(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    gap(); recv(b1[0]); gap(); recv(b1[1]);
    row(1, 1, 1, b1[2], 1, 0, 0, 0, 1, 0);
    recv(b1[3]);
    wr(BASE, 32'h001000B3, 1, b1[4]);
    recv(b1[4]); recv(b1[5]); gap(); recv(b1[6]); recv(b1[7]);
    wr(BASE + 4, 32'h000080B3, 1, 8'hEE);
`ifdef IMEM_LOADER_CHKSUM_EN
    gap(); recv(8'h90);
`endif
    row(0, 0, 1, 8'hEE, 0, 0, 0, 0, 1, 1);
    idle_r();
    run_table("t2");

    // Test 3: zero-length load.
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef IMEM_LOADER_CHKSUM_EN
    recv(8'h00);
`endif
    done_r(); idle_r();
    run_table("t3");

    // Test 4: reset after two bytes of word 0, then a fresh load.
    wr_q.delete();
    start_load(2);
    send_byte(8'h11); send_byte(8'h22);
    #2 w_rst_n = 0;
    #1;
    check("t4_rst", {w_in_ready, w_we, w_busy, w_cpu_hold, w_done, w_err, w_wa, w_wd},
          {6'b0, BASE, 32'h0});
    check("t4_nowr", wr_q.size(), 0);
    @(posedge w_clk); #1;
    w_rst_n = 1;
    bq = '{8'h44, 8'h33, 8'h22, 8'h11};
`ifdef IMEM_LOADER_CHKSUM_EN
    bq.push_back(8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11);
`endif
    start_load(1);
    finish_load("t4");
    check("t4_cnt", wr_q.size(), 1);
    if (wr_q.size() > 0) check("t4_wr", wr_q[0], {BASE, 32'h11223344});

`ifdef IMEM_LOADER_CHKSUM_EN
    // Test 5: bad checksum sets a sticky error cleared by the next start.
    bq.delete();
    foreach (b1[i]) bq.push_back(b1[i]);
    bq.push_back(8'h91);
    start_load(2);
    finish_load("t5a");
    check("t5_err", w_err, 1);
    repeat (3) begin @(posedge w_clk); #1; end
    check("t5_hold", w_err, 1);
    start_load(1);
    check("t5_clr", w_err, 0);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    finish_load("t5b");
    check("t5_ok", w_err, 0);
`endif

    // Test 6: oversize length saturates to DEPTH words.
    wr_q.delete(); bq.delete(); ck = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = mkw(i);
      for (int k = 0; k < 4; k++) begin
        bq.push_back(w[8*k +: 8]);
        ck ^= w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    bq.push_back(ck);
`endif
    start_load(DEPTH + 5);
    finish_load("t6");
    check("t6_cnt", wr_q.size(), DEPTH);
    foreach (wr_q[i]) check($sformatf("t6_w%0d", i), wr_q[i], {32'(BASE + 4 * i), mkw(i)});
    if (wr_q.size() > 0) check("t6_last", wr_q[wr_q.size() - 1][63:32], BASE + 4 * (DEPTH - 1));
    check("t6_idle", {w_busy, w_in_ready, w_err}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
